// File: rtl/sabr_mul_pkg.sv
// Shared constants and elaboration-time configuration checks for the SABR
// pipelined multiplier.
package sabr_mul_pkg;

   localparam logic MUL_UNSIGNED = 1'b0;
   localparam logic MUL_SIGNED   = 1'b1;
   localparam int   MAX_STAGE    = 8;

   function automatic bit sabr_mul_cfg_ok(input int num_stage, input int shift, input int prod_w);
      return (num_stage >= 1) && (num_stage <= MAX_STAGE) && (shift >= 0) && (shift < prod_w);
   endfunction

endpackage

// File: rtl/sabr_mul_stage.sv
// One pipeline slot: valid plus result/tag/mode payload, loaded when the
// slot advances. Payload only moves with a valid beat so bubbles stay quiet.
module sabr_mul_stage
   import sabr_mul_pkg::*;
#(
   parameter int DATA_W = 79,
   parameter int TAG_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ld,
   input  logic              v_d,
   input  logic [DATA_W-1:0] data_d,
   input  logic [TAG_W-1:0]  tag_d,
   input  logic              mode_d,
   output logic              v_q,
   output logic [DATA_W-1:0] data_q,
   output logic [TAG_W-1:0]  tag_q,
   output logic              mode_q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q    <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
         mode_q <= MUL_UNSIGNED;
      end else if (ld) begin
         v_q <= v_d;
         if (v_d) begin
            data_q <= data_d;
            tag_q  <= tag_d;
            mode_q <= mode_d;
         end
      end
   end

endmodule

// File: rtl/sabr_mul_pipe.sv
// Back-pressurable pipelined multiplier: signed/unsigned product with a fixed
// right shift, NUM_STAGE register slots that compact bubbles under stall.
module sabr_mul_pipe
   import sabr_mul_pkg::*;
#(
   parameter int DIN0_WIDTH = 40,
   parameter int DIN1_WIDTH = 40,
   parameter int DOUT_WIDTH = 79,
   parameter int NUM_STAGE  = 2,
   parameter int SHIFT      = 0,
   parameter int TAG_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_signed,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int P = DIN0_WIDTH + DIN1_WIDTH;
   // Stages carry only the bits that can differ; any widening to DOUT_WIDTH
   // is done at the output from the travelling mode bit.
   localparam int R = (DOUT_WIDTH < P) ? DOUT_WIDTH : P;

   if (!sabr_mul_cfg_ok(NUM_STAGE, SHIFT, P)) begin : g_bad_cfg
      $error("sabr_mul_pipe: NUM_STAGE must be 1..%0d and SHIFT below %0d", MAX_STAGE, P);
   end

   // A P+1 bit signed multiply covers both modes: unsigned operands get a
   // zero top bit, so the arithmetic shift then behaves as a logical one.
   logic              a_msb, b_msb;
   logic signed [P:0] a_w, b_w, prod_w;
   logic [R-1:0]      res_d;

   assign a_msb  = (in_signed == MUL_SIGNED) & din0[DIN0_WIDTH-1];
   assign b_msb  = (in_signed == MUL_SIGNED) & din1[DIN1_WIDTH-1];
   assign a_w    = {{(P+1-DIN0_WIDTH){a_msb}}, din0};
   assign b_w    = {{(P+1-DIN1_WIDTH){b_msb}}, din1};
   assign prod_w = a_w * b_w;
   assign res_d  = R'(prod_w >>> SHIFT);

   // Index 0 is the input beat; index k+1 is the output of stage k.
   logic [NUM_STAGE:0]                vld_pipe;
   logic [NUM_STAGE:0][R-1:0]         dat_pipe;
   logic [NUM_STAGE:0][TAG_WIDTH-1:0] tag_pipe;
   logic [NUM_STAGE:0]                mode_pipe;
   logic [NUM_STAGE-1:0]              adv;

   assign vld_pipe[0]  = in_valid;
   assign dat_pipe[0]  = res_d;
   assign tag_pipe[0]  = in_tag;
   assign mode_pipe[0] = in_signed;

   // A slot may load if it is empty or its contents move on this cycle.
   always_comb begin
      adv = '0;
      adv[NUM_STAGE-1] = !vld_pipe[NUM_STAGE] | out_ready;
      for (int k = NUM_STAGE - 2; k >= 0; k--)
         adv[k] = !vld_pipe[k+1] | adv[k+1];
   end

   for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
      sabr_mul_stage #(
         .DATA_W (R),
         .TAG_W  (TAG_WIDTH)
      ) u_stage (
         .clk     (clk),
         .reset_n (reset_n),
         .ld      (ce & adv[k]),
         .v_d     (vld_pipe[k]),
         .data_d  (dat_pipe[k]),
         .tag_d   (tag_pipe[k]),
         .mode_d  (mode_pipe[k]),
         .v_q     (vld_pipe[k+1]),
         .data_q  (dat_pipe[k+1]),
         .tag_q   (tag_pipe[k+1]),
         .mode_q  (mode_pipe[k+1])
      );
   end

   assign in_ready  = ce & adv[0];
   assign out_valid = vld_pipe[NUM_STAGE];
   assign out_tag   = tag_pipe[NUM_STAGE];

   if (DOUT_WIDTH > P) begin : g_ext
      logic ext_bit;
      assign ext_bit = (mode_pipe[NUM_STAGE] == MUL_SIGNED) & dat_pipe[NUM_STAGE][P-1];
      assign dout    = {{(DOUT_WIDTH-P){ext_bit}}, dat_pipe[NUM_STAGE]};
   end else begin : g_trunc
      // Result already fits the output; the mode bit has no further use here.
      logic unused_mode;
      assign unused_mode = mode_pipe[NUM_STAGE];
      assign dout        = dat_pipe[NUM_STAGE];
   end

endmodule

// File: tb/tb_sabr_mul_pipe.sv
// Randomised and directed bench for sabr_mul_pipe (16x16->16, 3 stages,
// fixed-point shift of 8) against a queue-based reference model.
module tb_sabr_mul_pipe;
   import sabr_mul_pkg::*;

   localparam int AW = 16, BW = 16, DW = 16, NS = 3, SH = 8, TW = 8;

   logic          clk = 1'b0, reset_n = 1'b1, ce = 1'b0;
   logic          in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
   logic [AW-1:0] din0 = '0;
   logic [BW-1:0] din1 = '0;
   logic [TW-1:0] in_tag = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] dout;
   logic [TW-1:0] out_tag;

   int checks = 0, errors = 0;

   typedef struct { logic [DW-1:0] d; logic [TW-1:0] t; } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   bit            ls[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [AW-1:0] la[4] = '{16'h0180, 16'hFFFE, 16'hFFFE, 16'hFFFF};
   logic [BW-1:0] lb[4] = '{16'hFF00, 16'h0003, 16'h0003, 16'hFFFF};
   logic [DW-1:0] le[4] = '{16'hFE80, 16'hFFFF, 16'h02FF, 16'hFE00};

   always #5 clk = ~clk;

   sabr_mul_pipe #(
      .DIN0_WIDTH (AW), .DIN1_WIDTH (BW), .DOUT_WIDTH (DW),
      .NUM_STAGE  (NS), .SHIFT      (SH), .TAG_WIDTH  (TW)
   ) dut (
      .clk (clk), .reset_n (reset_n), .ce (ce),
      .in_valid (in_valid), .in_ready (in_ready), .in_signed (in_signed),
      .din0 (din0), .din1 (din1), .in_tag (in_tag),
      .out_valid (out_valid), .out_ready (out_ready),
      .dout (dout), .out_tag (out_tag)
   );

   // Reference: exact integer product, shifted, truncated to the output.
   function automatic logic [DW-1:0] model(input logic s, input logic [AW-1:0] a, input logic [BW-1:0] b);
      longint pa, pb, p;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      p  = (pa * pb) >>> SH;
      return p[DW-1:0];
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(5))
         0:       return 16'h8000;
         1:       return 16'hFFFF;
         2:       return 16'h0000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: everything is sampled mid-cycle for the edge that follows.
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_d;
   logic [TW-1:0] prev_t;

   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_dout", 32'(dout), 32'(prev_d));
            chk("hold_tag", 32'(out_tag), 32'(prev_t));
         end
         chk("in_ready", 32'(in_ready), 32'(ce && !(sb.size() == NS && !out_ready)));
         if (out_valid && out_ready && ce) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected: got tag 0x%0h, want no beat", out_tag);
            end else begin
               mon_e = sb.pop_front();
               chk("dout", 32'(dout), 32'(mon_e.d));
               chk("out_tag", 32'(out_tag), 32'(mon_e.t));
            end
         end
         if (in_valid && in_ready && ce) begin
            mon_e.d = model(in_signed, din0, din1);
            mon_e.t = in_tag;
            sb.push_back(mon_e);
         end
         prev_stall = out_valid && !(out_ready && ce);
         prev_d     = dout;
         prev_t     = out_tag;
      end
   end

   task automatic lit_beat(input bit s, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [TW-1:0] t, input logic [DW-1:0] e);
      int lat;
      lat = 0;
      in_valid = 1'b1; in_signed = s; din0 = a; din1 = b; in_tag = t;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      while (!out_valid && lat < 10) begin
         lat++;
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'(NS - 1));
      chk("lit_dout", 32'(dout), 32'(e));
      chk("lit_tag", 32'(out_tag), 32'(t));
      cyc();
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0; ce = 1'b1; out_ready = 1'b1;
      while (sb.size() != 0 && n < 40) begin
         cyc();
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      cyc();
   endtask

   initial begin
      int  idx, c;
      bit  acc;
      logic          cap_v;
      logic [DW-1:0] cap_d;
      logic [TW-1:0] cap_t;

      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      chk("rst_in_ready_ce0", 32'(in_ready), 32'd0);
      cyc();
      reset_n = 1'b1; ce = 1'b1; out_ready = 1'b1;
      cyc();

      // Hand-computed products pin the reference model.
      for (int i = 0; i < 4; i++)
         lit_beat(ls[i], la[i], lb[i], 8'(i + 1), le[i]);

      // Backpressure: tags 1..10 with out_ready 1,0,0 repeating.
      idx = 1; c = 0;
      while (idx <= 10 && c < 100) begin
         in_valid = 1'b1; in_tag = 8'(idx);
         in_signed = 1'($urandom_range(1)); din0 = pick(); din1 = pick();
         out_ready = (c % 3 == 0);
         @(negedge clk);
         acc = in_ready;
         cyc();
         if (acc) idx++;
         c++;
      end
      in_valid = 1'b0;
      chk("bp_all_sent", 32'(idx), 32'd11);
      drain();

      // Bubble collapse under stall.
      out_ready = 1'b0;
      in_valid = 1'b1; in_tag = 8'h21; din0 = 16'h0100; din1 = 16'h0200; in_signed = MUL_UNSIGNED;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      in_valid = 1'b1; in_tag = 8'h22; din0 = 16'h0300; din1 = 16'h0100;
      cyc();
      in_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk("bubble_stall_valid", 32'(out_valid), 32'd1);
      chk("bubble_stall_tag", 32'(out_tag), 32'h21);
      cyc();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bubble_first_valid", 32'(out_valid), 32'd1);
      chk("bubble_first_tag", 32'(out_tag), 32'h21);
      cyc();
      @(negedge clk);
      chk("bubble_second_valid", 32'(out_valid), 32'd1);
      chk("bubble_second_tag", 32'(out_tag), 32'h22);
      drain();

      // Asynchronous reset with a full pipeline.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_tag = 8'(8'h31 + i); din0 = pick(); din1 = pick();
         cyc();
      end
      in_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_dout", 32'(dout), 32'd0);
      chk("arst_out_tag", 32'(out_tag), 32'd0);
      #5 reset_n = 1'b1;
      cyc();
      out_ready = 1'b1;
      cyc();
      @(negedge clk);
      chk("arst_flushed", 32'(out_valid), 32'd0);
      cyc();

      // Clock enable low freezes everything.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_tag = 8'(8'h41 + i); in_signed = MUL_SIGNED; din0 = pick(); din1 = pick();
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      @(negedge clk);
      cap_v = out_valid; cap_d = dout; cap_t = out_tag;
      cyc();
      ce = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_tag = 8'h4F;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ce_hold_valid", 32'(out_valid), 32'(cap_v));
         chk("ce_hold_dout", 32'(dout), 32'(cap_d));
         chk("ce_hold_tag", 32'(out_tag), 32'(cap_t));
         cyc();
      end
      in_valid = 1'b0; ce = 1'b1;
      drain();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         ce        = ($urandom_range(9) != 0);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_signed = 1'($urandom_range(1));
         din0      = pick();
         din1      = pick();
         in_tag    = 8'($urandom);
         cyc();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
